// File: rtl/twiddle_seq_ctrl.sv
// Frame sequencer for the CSD twiddle-multiplier stage of the N=128 parallel FFT.
// Counts accepted samples and forwards each one with its twiddle select and a last flag.
module twiddle_seq_ctrl #(
    parameter int NBITS   = 12,
    parameter int NPOINTS = 128,
    parameter int LOG2N   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NBITS-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*NBITS-1:0] out_data,
    output logic [1:0]         out_sel,
    output logic               out_last,
    output logic [LOG2N-1:0]   sample_idx,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPOINTS - 1);

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic [2*NBITS-1:0] data_q, data_d;
    logic [1:0]         sel_q, sel_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               accept;
    logic               xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vld_d    = vld_q;
        data_d   = data_q;
        sel_d    = sel_q;
        last_d   = last_q;
        done_d   = 1'b0;
        in_ready = (state_q == RUN) && (!vld_q || out_ready);
        accept   = in_valid && in_ready;
        xfer     = vld_q && out_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (accept && idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register reloads on accept even when the old word leaves the same cycle.
        if (accept) begin
            data_d = in_data;
            sel_d  = idx_q[1:0];
            last_d = (idx_q == LAST_IDX);
            vld_d  = 1'b1;
            idx_d  = idx_q + 1'b1;
        end else if (xfer) begin
            vld_d  = 1'b0;
        end
    end

    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign out_sel    = sel_q;
    assign out_last   = last_q;
    assign sample_idx = idx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule
